vreg_read_sequencer: RTL and testbench
======================================

Name: vreg_read_sequencer

Overview:
Decode-stage controller that sequences operand reads from the single-read-port vector register file. Each accepted instruction is classified by its 5-bit opcode into a source-read class: none, R3 only, R2 only, or both. The block then issues one register-file read per cycle and collects the returned data. It presents the complete operand bundle to the execute stage through a valid/ready handshake, stalling the fetch side while busy, and counts stall cycles.

Parameters:
VW, 128, vector register data width in bits
AW, 5, register address width
CNTW, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
instr_valid  in  1  decoded instruction present
instr_ready  out  1  sequencer can accept an instruction
opcode  in  5  instruction opcode
r2_addr  in  AW  source register R2 address
r3_addr  in  AW  source register R3 address
rf_re  out  1  register-file read enable
rf_raddr  out  AW  register-file read address
rf_rdata  in  VW  read data, valid exactly 1 cycle after rf_re
out_valid  out  1  operand bundle valid
out_ready  in  1  execute stage accepts bundle
out_opcode  out  5  latched opcode
out_sel  out  2  read class: 00 none, 01 R3, 10 R2, 11 both
src2_data  out  VW  R2 operand, zero if not read
src3_data  out  VW  R3 operand, zero if not read
stall_cnt  out  CNTW  saturating count of stalled cycles

Behaviour:
- Reset: clk edge with rst=0. Forces the following:
  - state=IDLE.
  - All outputs 0 except instr_ready, which is 1.
  - rf_re=0.
  - Operand, opcode, sel and stall_cnt registers cleared.
  - Any in-flight instruction is dropped. A read whose data would arrive after reset is ignored.
- Read class decode, purely from opcode; every other opcode maps to 11:
  - 10001 -> 00; 10011 -> 00
  - 10101 -> 01; 10111 -> 01
  - 01001 -> 10; 11011 -> 10
- FSM states: IDLE, RD_R2, RD_R3, LAST, OUT.
- IDLE:
  - instr_ready=1.
  - On instr_valid, latch opcode, sel, r2_addr and r3_addr, and clear src2_data and src3_data.
  - Next state: sel=00 -> OUT; sel=10 or 11 -> RD_R2; sel=01 -> RD_R3.
- RD_R2: rf_re=1, rf_raddr=latched r2. Next state: RD_R3 if sel=11, else LAST.
- RD_R3: rf_re=1, rf_raddr=latched r3. Next state: LAST.
- LAST: rf_re=0. Next state: OUT.
- Capture rule: when rf_re was 1 in the previous cycle, rf_rdata is registered into the operand matching the previous rf_raddr source (R2 -> src2_data, R3 -> src3_data). With sel=11, the R2 data is captured during RD_R3, so the second read is back-to-back (pipelined).
- OUT:
  - out_valid=1. Outputs are stable while out_ready=0.
  - On out_ready, go to IDLE. out_valid drops the next cycle.
  - A new instruction can be accepted no earlier than the cycle after the handshake.
- instr_ready=0 in every state except IDLE.
- rf_re is never asserted outside RD_R2 and RD_R3. rf_raddr=0 whenever rf_re=0.
- Latency from the accept edge to out_valid high:
  - sel 00: 1 cycle
  - sel 01 or 10: 3 cycles
  - sel 11: 4 cycles
- stall_cnt increments on each cycle with instr_valid=1 and instr_ready=0. It saturates at 2^CNTW-1 and never wraps.
- If both registers are the same (r2_addr=r3_addr), two reads are still issued. Both operands are then equal.
- The block does not require instr_valid to stay high outside IDLE; the instruction is already latched.

Test Plan:
- Reset check: rst=0 for 2 cycles, then rst=1 -> instr_ready=1, out_valid=0, rf_re=0, stall_cnt=0.
- Class 11 read: opcode 00000, r2=3, r3=7, RF returns 0xAAAA.. for reg 3 and 0x5555.. for reg 7.
  - Expect rf_re high for 2 consecutive cycles with addresses 3 then 7.
  - Expect out_valid 4 cycles after accept with src2=0xAAAA.., src3=0x5555.. and out_sel=11.
- Single-source classes:
  - Opcode 10101, r3=9 -> one read of address 9; out_valid 3 cycles after accept; src2=0; out_sel=01.
  - Opcode 01001, r2=4 -> one read of address 4; src3=0; out_sel=10.
- No-source class: opcode 10011 -> no rf_re at all; out_valid 1 cycle after accept; both operands 0; out_sel=00.
- Backpressure: hold out_ready=0 for 5 cycles in OUT while instr_valid=1.
  - Expect outputs stable and instr_ready=0.
  - Expect stall_cnt to increment by 1 for every cycle instr_valid=1 and instr_ready=0, from the accept onward.
  - On release, exactly one handshake occurs, then IDLE.
- Reset mid-operation: assert rst=0 during RD_R3.
  - Next cycle: state IDLE, rf_re=0, out_valid=0, operands 0.
  - Stale rf_rdata is not captured.
  - A new instruction afterwards completes normally.

Source files
------------

// File: rtl/vreg_read_sequencer.sv
// Operand-read sequencer for the single-port vector register file: issues up to
// two pipelined reads per instruction and hands the operand bundle to execute.
module vreg_read_sequencer #(
   parameter int unsigned VW   = 128,
   parameter int unsigned AW   = 5,
   parameter int unsigned CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [4:0]      opcode,
   input  logic [AW-1:0]   r2_addr,
   input  logic [AW-1:0]   r3_addr,
   output logic            rf_re,
   output logic [AW-1:0]   rf_raddr,
   input  logic [VW-1:0]   rf_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4:0]      out_opcode,
   output logic [1:0]      out_sel,
   output logic [VW-1:0]   src2_data,
   output logic [VW-1:0]   src3_data,
   output logic [CNTW-1:0] stall_cnt
);

   typedef enum logic [2:0] {IDLE, RD_R2, RD_R3, LAST, OUT} state_t;

   state_t        state;
   logic [AW-1:0] r2_q;
   logic [AW-1:0] r3_q;
   logic          cap_en;
   logic          cap_r3;
   logic [1:0]    sel_new;

   // Source-read class: bit 1 = R2 needed, bit 0 = R3 needed
   function automatic logic [1:0] decode_sel(input logic [4:0] op);
      case (op)
         5'b10001, 5'b10011: decode_sel = 2'b00;
         5'b10101, 5'b10111: decode_sel = 2'b01;
         5'b01001, 5'b11011: decode_sel = 2'b10;
         default:            decode_sel = 2'b11;
      endcase
   endfunction

   always_comb begin
      sel_new = decode_sel(opcode);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         instr_ready <= 1'b1;
         rf_re       <= 1'b0;
         rf_raddr    <= '0;
         out_valid   <= 1'b0;
         out_opcode  <= '0;
         out_sel     <= '0;
         src2_data   <= '0;
         src3_data   <= '0;
         stall_cnt   <= '0;
         r2_q        <= '0;
         r3_q        <= '0;
         cap_en      <= 1'b0;
         cap_r3      <= 1'b0;
      end else begin
         // Read data returns one cycle after the request; route it by the source read
         cap_en <= rf_re;
         cap_r3 <= (state == RD_R3);
         if (cap_en) begin
            if (cap_r3) src3_data <= rf_rdata;
            else        src2_data <= rf_rdata;
         end

         if (instr_valid && !instr_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNTW'(1);

         case (state)
            IDLE: begin
               if (instr_valid) begin
                  out_opcode  <= opcode;
                  out_sel     <= sel_new;
                  r2_q        <= r2_addr;
                  r3_q        <= r3_addr;
                  src2_data   <= '0;
                  src3_data   <= '0;
                  instr_ready <= 1'b0;
                  case (sel_new)
                     2'b00: begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                     end
                     2'b01: begin
                        state    <= RD_R3;
                        rf_re    <= 1'b1;
                        rf_raddr <= r3_addr;
                     end
                     default: begin
                        state    <= RD_R2;
                        rf_re    <= 1'b1;
                        rf_raddr <= r2_addr;
                     end
                  endcase
               end
            end
            RD_R2: begin
               if (out_sel == 2'b11) begin
                  state    <= RD_R3;
                  rf_re    <= 1'b1;
                  rf_raddr <= r3_q;
               end else begin
                  state    <= LAST;
                  rf_re    <= 1'b0;
                  rf_raddr <= '0;
               end
            end
            RD_R3: begin
               state    <= LAST;
               rf_re    <= 1'b0;
               rf_raddr <= '0;
            end
            LAST: begin
               state     <= OUT;
               out_valid <= 1'b1;
            end
            OUT: begin
               if (out_ready) begin
                  state       <= IDLE;
                  out_valid   <= 1'b0;
                  instr_ready <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               rf_re       <= 1'b0;
               rf_raddr    <= '0;
               out_valid   <= 1'b0;
               instr_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vreg_read_sequencer.sv
// Bench for vreg_read_sequencer: transaction-level timeline model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_vreg_read_sequencer;

   localparam int unsigned VW   = 128;
   localparam int unsigned AW   = 5;
   localparam int unsigned CNTW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            instr_valid;
   logic            instr_ready;
   logic [4:0]      opcode;
   logic [AW-1:0]   r2_addr;
   logic [AW-1:0]   r3_addr;
   logic            rf_re;
   logic [AW-1:0]   rf_raddr;
   logic [VW-1:0]   rf_rdata;
   logic            out_valid;
   logic            out_ready;
   logic [4:0]      out_opcode;
   logic [1:0]      out_sel;
   logic [VW-1:0]   src2_data;
   logic [VW-1:0]   src3_data;
   logic [CNTW-1:0] stall_cnt;

   vreg_read_sequencer #(.VW(VW), .AW(AW), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .opcode(opcode), .r2_addr(r2_addr), .r3_addr(r3_addr),
      .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_sel(out_sel),
      .src2_data(src2_data), .src3_data(src3_data),
      .stall_cnt(stall_cnt)
   );

   initial forever #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [VW-1:0] mem [32];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Register file: answers one cycle after a read, garbage otherwise
   logic          pv;
   logic [AW-1:0] pa;
   always @(posedge clk) begin
      pv = rf_re;
      pa = rf_raddr;
      #1;
      rf_rdata = pv ? mem[pa] : {$urandom, $urandom, $urandom, $urandom};
   end

   function automatic logic [1:0] cls(input logic [4:0] op);
      case (op)
         5'b10001, 5'b10011: cls = 2'b00;
         5'b10101, 5'b10111: cls = 2'b01;
         5'b01001, 5'b11011: cls = 2'b10;
         default:            cls = 2'b11;
      endcase
   endfunction

   // Timeline model: each instruction is an accept cycle t0 plus offsets derived from its class
   bit              mvalid = 0;
   bit              busy   = 0;
   int              cyc    = 0;
   int              t0     = 0;
   int              lat    = 0;
   int              nrd    = 0;
   logic [AW-1:0]   ra [2];
   logic [1:0]      msel   = '0;
   logic [4:0]      mop    = '0;
   logic [VW-1:0]   es2    = '0;
   logic [VW-1:0]   es3    = '0;
   logic [CNTW-1:0] est    = '0;

   always @(negedge clk) begin
      int            k;
      logic          re;
      logic          ov;
      logic [AW-1:0] ad;
      k  = cyc - t0;
      re = busy && (k >= 1) && (k <= nrd);
      ov = busy && (k >= lat);
      ad = re ? ra[k-1] : '0;
      if (mvalid) begin
         chk("instr_ready", instr_ready, !busy);
         chk("rf_re", rf_re, re);
         chk("rf_raddr", rf_raddr, ad);
         chk("out_valid", out_valid, ov);
         chk("stall_cnt", stall_cnt, est);
         chk("out_opcode", out_opcode, mop);
         chk("out_sel", out_sel, msel);
         if (!busy || ov) begin
            chk("src2_data", src2_data, es2);
            chk("src3_data", src3_data, es3);
         end
      end
      if (!rst) begin
         mvalid = 1; busy = 0; est = '0; es2 = '0; es3 = '0; msel = '0; mop = '0;
      end else if (mvalid) begin
         if (instr_valid && busy && (est != '1)) est++;
         if (!busy && instr_valid) begin
            busy = 1; t0 = cyc; mop = opcode; msel = cls(opcode);
            case (msel)
               2'b00:   begin nrd = 0; lat = 1; end
               2'b01:   begin nrd = 1; lat = 3; ra[0] = r3_addr; end
               2'b10:   begin nrd = 1; lat = 3; ra[0] = r2_addr; end
               default: begin nrd = 2; lat = 4; ra[0] = r2_addr; ra[1] = r3_addr; end
            endcase
            es2 = msel[1] ? mem[r2_addr] : '0;
            es3 = msel[0] ? mem[r3_addr] : '0;
         end else if (busy && ov && out_ready) begin
            busy = 0;
         end
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] op, input logic [AW-1:0] a2,
                        input logic [AW-1:0] a3, output int l);
      instr_valid = 1'b1; opcode = op; r2_addr = a2; r3_addr = a3;
      tick();
      instr_valid = 1'b0;
      l = 1;
      while (!out_valid && l < 12) begin
         tick();
         l++;
      end
      if (!out_valid) begin
         n_chk++; n_fail++;
         $display("FAIL out_valid timeout: got 0 expected 1 at %0t", $time);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int l;
      for (int i = 0; i < 32; i++) mem[i] = {4{32'hC0DE0000 | 32'(i)}};
      mem[3] = {32{4'hA}};
      mem[7] = {32{4'h5}};
      rf_rdata = '0; rst = 1'b0; instr_valid = 1'b0; out_ready = 1'b1;
      opcode = '0; r2_addr = '0; r3_addr = '0;
      tick(); tick();
      rst = 1'b1;
      chk("rst instr_ready", instr_ready, 1);
      chk("rst out_valid", out_valid, 0);
      chk("rst rf_re", rf_re, 0);
      chk("rst stall_cnt", stall_cnt, 0);
      tick();

      issue(5'b00000, 5'd3, 5'd7, l);
      chk("lat11", l, 4);
      chk("c11 src2", src2_data, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA);
      chk("c11 src3", src3_data, 128'h55555555555555555555555555555555);
      chk("c11 sel", out_sel, 2'b11);
      tick(); tick();

      issue(5'b10101, 5'd0, 5'd9, l);
      chk("lat01", l, 3);
      chk("c01 src2", src2_data, 0);
      chk("c01 src3", src3_data, 128'hC0DE0009C0DE0009C0DE0009C0DE0009);
      chk("c01 sel", out_sel, 2'b01);
      tick(); tick();

      issue(5'b01001, 5'd4, 5'd1, l);
      chk("lat10", l, 3);
      chk("c10 src2", src2_data, 128'hC0DE0004C0DE0004C0DE0004C0DE0004);
      chk("c10 src3", src3_data, 0);
      chk("c10 sel", out_sel, 2'b10);
      tick(); tick();

      issue(5'b10011, 5'd2, 5'd3, l);
      chk("lat00", l, 1);
      chk("c00 src2", src2_data, 0);
      chk("c00 src3", src3_data, 0);
      chk("c00 sel", out_sel, 2'b00);
      tick(); tick();

      issue(5'b11111, 5'd6, 5'd6, l);
      chk("same src2", src2_data, 128'hC0DE0006C0DE0006C0DE0006C0DE0006);
      chk("same src3", src3_data, 128'hC0DE0006C0DE0006C0DE0006C0DE0006);
      tick(); tick();

      // Backpressure with a waiting instruction behind the held bundle
      out_ready = 1'b0;
      instr_valid = 1'b1; opcode = 5'b10111; r2_addr = 5'd0; r3_addr = 5'd2;
      tick();
      tick(); tick();
      chk("bp out_valid", out_valid, 1);
      for (int i = 0; i < 5; i++) tick();
      chk("bp stall 7", stall_cnt, 7);
      chk("bp instr_ready", instr_ready, 0);
      chk("bp src3", src3_data, 128'hC0DE0002C0DE0002C0DE0002C0DE0002);
      out_ready = 1'b1;
      tick();
      instr_valid = 1'b0;
      chk("bp stall 8", stall_cnt, 8);
      chk("bp idle", instr_ready, 1);
      chk("bp drop", out_valid, 0);
      tick();

      // Reset while the R3 read is outstanding
      instr_valid = 1'b1; opcode = 5'b00000; r2_addr = 5'd1; r3_addr = 5'd5;
      tick();
      instr_valid = 1'b0;
      chk("mid r2 addr", rf_raddr, 5'd1);
      tick();
      chk("mid r3 addr", rf_raddr, 5'd5);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mid rf_re", rf_re, 0);
      chk("mid out_valid", out_valid, 0);
      chk("mid ready", instr_ready, 1);
      chk("mid src2", src2_data, 0);
      chk("mid stall", stall_cnt, 0);
      tick();
      chk("stale src3", src3_data, 0);
      chk("stale src2", src2_data, 0);
      issue(5'b00000, 5'd3, 5'd7, l);
      chk("post lat", l, 4);
      chk("post src2", src2_data, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA);
      chk("post src3", src3_data, 128'h55555555555555555555555555555555);
      tick(); tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
